// File: rtl/conv_channel_accumulator_if.sv
// rtl/conv_channel_accumulator_if.sv - channel input streams, bias and output stream of the channel accumulator
interface conv_channel_accumulator_if #(
  parameter int NUM_CH = 6,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 32
);
  logic [NUM_CH*IN_W-1:0] ch_data;
  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH-1:0]      ch_ready;
  logic [IN_W-1:0]        bias;
  logic [OUT_W-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   finish;
  logic                   sat_flag;
  logic                   busy;

  modport master (
    output ch_data, ch_valid, bias, out_ready,
    input  ch_ready, out_data, out_valid, out_last, finish, sat_flag, busy
  );

  modport slave (
    input  ch_data, ch_valid, bias, out_ready,
    output ch_ready, out_data, out_valid, out_last, finish, sat_flag, busy
  );
endinterface

// File: rtl/conv_channel_accumulator.sv
// rtl/conv_channel_accumulator.sv - re-aligns NUM_CH partial-sum streams, adds bias, requantises and clamps
// Three-stage pipeline (sum, shift, clamp) behind per-channel FIFOs; tracks feature-map boundaries.
module conv_channel_accumulator #(
  parameter int          NUM_CH         = 6,
  parameter int          IN_W           = 32,
  parameter int          OUT_W          = 32,
  parameter int          SHIFT          = 8,
  parameter logic [31:0] SAT_MAX        = 32'h0001_0000,
  parameter bit          RELU           = 1'b1,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          PIXELS_PER_MAP = 64
) (
  input  logic                        clk_global,
  input  logic                        reset,
  conv_channel_accumulator_if.slave   io
);
  localparam int SUM_W = IN_W + $clog2(NUM_CH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(PIXELS_PER_MAP);
  localparam logic [AW:0]              DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]            LAST_IDX = CW'(PIXELS_PER_MAP - 1);
  localparam logic signed [SUM_W-1:0]  POS_LIM  = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0]  NEG_LIM  = -POS_LIM;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  logic [IN_W-1:0]  mem_q    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q [NUM_CH];
  logic [AW-1:0]    rd_ptr_q [NUM_CH];
  logic [AW:0]      cnt_q    [NUM_CH];
  logic [NUM_CH-1:0] full, nonempty, push;
  logic adv, pop, accept, last;

  logic                    s1_valid_q, s2_valid_q, out_valid_q;
  logic signed [SUM_W-1:0] s1_sum_q, s2_sh_q, sum_d;
  logic [OUT_W-1:0]        out_data_q, clamp_d;
  logic                    sat_now, sat_q;
  logic [CW-1:0]           pix_cnt_q;
  state_t                  state_q, state_d;

  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]     = (cnt_q[k] == DEPTH_C);
      nonempty[k] = (cnt_q[k] != '0);
      push[k]     = io.ch_valid[k] && !full[k];
    end
  end

  assign adv    = !out_valid_q || io.out_ready;
  assign pop    = (&nonempty) && adv;
  assign accept = out_valid_q && io.out_ready;
  assign last   = out_valid_q && (pix_cnt_q == LAST_IDX);

  always_ff @(posedge clk_global or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop)     rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        case ({push[k], pop})
          2'b10:   cnt_q[k] <= cnt_q[k] + 1'b1;
          2'b01:   cnt_q[k] <= cnt_q[k] - 1'b1;
          default: cnt_q[k] <= cnt_q[k];
        endcase
      end
    end
  end

  // FIFO storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk_global) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= io.ch_data[k*IN_W +: IN_W];
    end
  end

  always_comb begin
    sum_d = SUM_W'(signed'(io.bias));
    for (int k = 0; k < NUM_CH; k++) begin
      sum_d = sum_d + SUM_W'(signed'(mem_q[k][rd_ptr_q[k]]));
    end
  end

  always_comb begin
    clamp_d = OUT_W'(s2_sh_q);
    sat_now = 1'b0;
    if (s2_sh_q >= POS_LIM) begin
      clamp_d = OUT_W'(POS_LIM);
      sat_now = 1'b1;
    end else if (RELU && s2_sh_q[SUM_W-1]) begin
      clamp_d = '0;
    end else if (!RELU && (s2_sh_q <= NEG_LIM)) begin
      clamp_d = OUT_W'(NEG_LIM);
      sat_now = 1'b1;
    end
  end

  always_ff @(posedge clk_global or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_sum_q    <= '0;
      s2_sh_q     <= '0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= pop;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (pop)        s1_sum_q   <= sum_d;
      if (s1_valid_q) s2_sh_q    <= s1_sum_q >>> SHIFT;
      if (s2_valid_q) out_data_q <= clamp_d;
    end
  end

  // The flag restarts on the accepting edge of a map's last pixel, so a saturated
  // first pixel of the next map loaded on that same edge is still recorded.
  always_ff @(posedge clk_global or posedge reset) begin
    if (reset) begin
      pix_cnt_q <= '0;
      sat_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      if (accept) pix_cnt_q <= last ? '0 : pix_cnt_q + 1'b1;
      sat_q   <= ((accept && last) ? 1'b0 : sat_q) | (adv && s2_valid_q && sat_now);
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|push) state_d = ST_RUN;
      ST_RUN:  if (accept && last) state_d = ST_DONE;
      ST_DONE: state_d = ((|nonempty) || (|push)) ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.ch_ready  = ~full;
  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = last;
  assign io.finish    = (state_q == ST_DONE);
  assign io.sat_flag  = sat_q;
  assign io.busy      = (state_q != ST_IDLE) || (|nonempty);
endmodule

// File: tb/tb_conv_channel_accumulator.sv
// tb/tb_conv_channel_accumulator.sv - randomized scoreboard bench for conv_channel_accumulator
module tb_conv_channel_accumulator;
  localparam int NUM_CH = 6;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 32;
  localparam int PPM    = 64;
  localparam longint SAT_MAX = 64'h1_0000;
  localparam logic [NUM_CH-1:0] ALL  = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] NONE = '0;

  logic clk_global = 1'b0;
  logic reset;
  always #5 clk_global = ~clk_global;

  conv_channel_accumulator_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) io ();

  conv_channel_accumulator #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_global(clk_global),
    .reset     (reset),
    .io        (io)
  );

  int errs = 0;
  int checks = 0;
  longint chq [NUM_CH][$];
  longint expq[$];
  bit     expsat[$];
  int     acc_cnt = 0;
  bit     sat_acc = 0;
  bit     exp_fin = 0;
  longint bias_v = 0;
  int     fin_pulses = 0;
  logic [IN_W-1:0]   nxt [NUM_CH];
  logic [NUM_CH-1:0] pushed_mask;
  bit                seen_valid;
  logic [OUT_W-1:0]  seen_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rand_val(input bit big);
    int r;
    r = $urandom;
    return big ? 32'(r) : 32'(r >>> 12);
  endfunction

  // Reference: a pixel exists once every channel has delivered its value for it.
  task automatic model_pop();
    longint s, sh;
    bit all_ready;
    forever begin
      all_ready = 1;
      for (int k = 0; k < NUM_CH; k++) if (chq[k].size() == 0) all_ready = 0;
      if (!all_ready) break;
      s = bias_v;
      for (int k = 0; k < NUM_CH; k++) s += chq[k].pop_front();
      sh = s >>> 8;
      if (sh >= SAT_MAX) begin expq.push_back(SAT_MAX); expsat.push_back(1'b1); end
      else if (sh <= 0)  begin expq.push_back(0);       expsat.push_back(1'b0); end
      else               begin expq.push_back(sh);      expsat.push_back(1'b0); end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_CH; k++) chq[k].delete();
    expq.delete();
    expsat.delete();
    acc_cnt = 0;
    sat_acc = 0;
    exp_fin = 0;
  endtask

  task automatic step(input logic [NUM_CH-1:0] v, input bit rdy);
    bit acc, lst;
    @(negedge clk_global);
    for (int k = 0; k < NUM_CH; k++) io.ch_data[k*IN_W +: IN_W] = nxt[k];
    io.ch_valid  = v;
    io.out_ready = rdy;
    io.bias      = bias_v[IN_W-1:0];
    #1;
    check_eq("finish", io.finish, exp_fin);
    if (io.finish) fin_pulses++;
    exp_fin    = 0;
    seen_valid = io.out_valid;
    seen_data  = io.out_data;
    acc        = io.out_valid && rdy;
    if (io.out_valid && expq.size() == 0) check_eq("spurious_valid", io.out_valid, 1'b0);
    if (io.out_valid && expq.size() != 0) begin
      check_eq(acc ? "out_data" : "stall_data", io.out_data, expq[0]);
      if (acc) begin
        lst     = (acc_cnt % PPM) == PPM - 1;
        sat_acc = ((acc_cnt % PPM) == 0) ? expsat[0] : (sat_acc | expsat[0]);
        check_eq("out_last", io.out_last, lst);
        check_eq("sat_flag", io.sat_flag, sat_acc);
        exp_fin = lst;
        acc_cnt++;
        void'(expq.pop_front());
        void'(expsat.pop_front());
      end
    end
    pushed_mask = v & io.ch_ready;
    for (int k = 0; k < NUM_CH; k++)
      if (pushed_mask[k]) chq[k].push_back(longint'($signed(nxt[k])));
    @(posedge clk_global);
    model_pop();
  endtask

  task automatic push_pixel(input bit big);
    for (int k = 0; k < NUM_CH; k++) nxt[k] = rand_val(big);
    for (int t = 0; t < 50; t++) begin
      step(ALL, 1'b1);
      if (pushed_mask == ALL) return;
    end
    check_eq("push_timeout", pushed_mask, ALL);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 100) begin
      step(NONE, 1'b1);
      t++;
    end
    check_eq("drain", expq.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_global);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_out_valid", io.out_valid, 1'b0);
    check_eq("rst_out_data",  io.out_data, 0);
    check_eq("rst_out_last",  io.out_last, 1'b0);
    check_eq("rst_ch_ready",  io.ch_ready, ALL);
    check_eq("rst_busy",      io.busy, 1'b0);
    check_eq("rst_sat",       io.sat_flag, 1'b0);
    check_eq("rst_finish",    io.finish, 1'b0);
    clear_model();
    io.ch_valid = NONE;
    repeat (2) @(posedge clk_global);
    @(negedge clk_global);
    reset = 1'b0;
  endtask

  initial begin
    int k_lat;
    logic [OUT_W-1:0] held;
    reset        = 1'b1;
    io.ch_valid  = NONE;
    io.ch_data   = '0;
    io.bias      = '0;
    io.out_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) nxt[k] = '0;
    apply_reset();

    // minimum latency from push to out_valid
    bias_v = 0;
    for (int k = 0; k < NUM_CH; k++) nxt[k] = 32'h0000_0100;
    step(ALL, 1'b1);
    k_lat = 0;
    while (k_lat < 10) begin
      step(NONE, 1'b1);
      if (seen_valid) break;
      k_lat++;
    end
    check_eq("latency", k_lat, 3);
    check_eq("first_pixel", seen_data, 6);
    drain();

    // ceiling saturation then ReLU zero clamp
    for (int k = 0; k < NUM_CH; k++) nxt[k] = 32'h0040_0000;
    step(ALL, 1'b1);
    for (int k = 0; k < NUM_CH; k++) nxt[k] = 32'hFFFF_FF00;
    step(ALL, 1'b1);
    drain();
    #1 check_eq("busy_run", io.busy, 1'b1);

    // skewed channels: ch5 idle while ch0-4 fill
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NUM_CH; k++) nxt[k] = rand_val(0);
      step(6'b011111, 1'b1);
    end
    #1;
    check_eq("skew_ready", io.ch_ready, 6'b100000);
    check_eq("skew_no_valid", io.out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nxt[5] = rand_val(0);
      step(6'b100000, 1'b1);
    end
    drain();

    // output stall
    bias_v = longint'($urandom_range(0, 4096));
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NUM_CH; k++) nxt[k] = rand_val(0);
      step(ALL, 1'b0);
    end
    held = seen_data;
    check_eq("stall_valid", seen_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(NONE, 1'b0);
      check_eq("stall_hold", seen_data, held);
    end
    #1 check_eq("stall_no_pop", io.ch_ready, NONE);
    step(NONE, 1'b1);
    step(NONE, 1'b1);
    check_eq("release_next", seen_valid, 1'b1);
    drain();

    // full frame with early saturation
    apply_reset();
    bias_v = longint'($urandom_range(0, 100000));
    fin_pulses = 0;
    for (int p = 0; p < 66; p++) push_pixel(p == 2);
    drain();
    step(NONE, 1'b1);
    check_eq("frame_finish", fin_pulses, 1);

    // reset mid-frame with FIFOs loaded, then a clean frame
    for (int p = 0; p < 30; p++) push_pixel(0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NUM_CH; k++) nxt[k] = rand_val(0);
      step(ALL, 1'b0);
    end
    apply_reset();
    fin_pulses = 0;
    for (int p = 0; p < PPM; p++) push_pixel(p[3:0] == 4'd5);
    drain();
    step(NONE, 1'b1);
    check_eq("reframe_finish", fin_pulses, 1);

    // randomized traffic
    apply_reset();
    bias_v = longint'($signed($urandom)) >>> 8;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NUM_CH; k++) nxt[k] = rand_val($urandom_range(0, 3) == 0);
      step(NEXT_MASK(), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  function automatic logic [NUM_CH-1:0] NEXT_MASK();
    logic [NUM_CH-1:0] m;
    m = ($urandom_range(0, 1) == 0) ? ALL : NUM_CH'($urandom);
    return m;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
